// File: rtl/row_config_loader.sv
// row_config_loader: assembles a word-wide configuration stream into a shadow
// register and commits it to brbselect only after a complete, error-free load,
// so the routing fabric never sees a partial configuration.
module row_config_loader #(
    parameter  int wire_width = 3,
    parameter  int fpga_width = 5,
    parameter  int word_width = 8,
    localparam int CFG_BITS   = fpga_width * wire_width * 12,
    localparam int NWORDS     = (CFG_BITS + word_width - 1) / word_width,
    localparam int PAD        = NWORDS * word_width - CFG_BITS,
    localparam int CNT_W      = $clog2(NWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [word_width-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [CFG_BITS-1:0]   brbselect,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   counter;
    logic [CFG_BITS-1:0] shadow;

    logic load_start;   // accepted start: clear counter, shadow and cfg_err
    logic accept;       // handshake on a word this cycle
    logic err_set;      // last word carried nonzero pad bits
    logic last_word;
    logic pad_bad;

    assign last_word = (counter == CNT_W'(NWORDS - 1));
    assign busy      = (state != IDLE);

    // Pad bits exist only when the stream is wider than the configuration.
    if (PAD > 0) begin : g_pad
        assign pad_bad = |cfg_data[word_width-1:word_width-PAD];
    end else begin : g_no_pad
        assign pad_bad = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
        state_next = state;
        cfg_ready  = 1'b0;
        load_start = 1'b0;
        accept     = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_next = LOAD;
                    load_start = 1'b1;
                end
            end
            LOAD: begin
                // a word offered alongside abort is refused
                cfg_ready = !abort;
                if (abort) begin
                    state_next = IDLE;
                end else if (cfg_valid) begin
                    accept = 1'b1;
                    if (last_word) begin
                        if (pad_bad) begin
                            err_set    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = COMMIT;
                        end
                    end
                end
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word assembly, error flag, commit of the shadow and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow is reset too, so a reset mid-load leaves no stale words behind.
            counter   <= '0;
            shadow    <= '0;
            cfg_err   <= 1'b0;
            brbselect <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == COMMIT) brbselect <= shadow;

            if (load_start) begin
                counter <= '0;
                shadow  <= '0;
                cfg_err <= 1'b0;
            end else if (accept) begin
                // bit i of the configuration lives in word i/word_width
                for (int i = 0; i < CFG_BITS; i++) begin
                    if (counter == CNT_W'(i / word_width)) shadow[i] <= cfg_data[i % word_width];
                end
                counter <= counter + CNT_W'(1);
            end

            if (err_set) cfg_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_row_config_loader.sv
// Bench for row_config_loader: directed loads with per-cycle expectations
// derived from the stimulus, checked on every falling edge.
module tb_row_config_loader;

    localparam int WW = 8;
    localparam int CB = 5 * 3 * 12;
    localparam int NW = (CB + WW - 1) / WW;

    typedef logic [WW-1:0] words_t [NW];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CB-1:0] brbselect;
    logic          busy;
    logic          done;
    logic          cfg_err;

    // expected outputs for the current cycle
    logic [CB-1:0] exp_brb;
    logic          exp_busy;
    logic          exp_ready;
    logic          exp_done;
    logic          exp_err;
    bit            chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    row_config_loader #(.wire_width(3), .fpga_width(5), .word_width(WW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .brbselect (brbselect),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected configuration: bit i comes from word i/WW, bit i%WW.
    function automatic logic [CB-1:0] build(input words_t w);
        logic [CB-1:0] r = '0;
        for (int k = 0; k < NW; k++)
            for (int b = 0; b < WW; b++)
                if (k * WW + b < CB) r[k * WW + b] = w[k][b];
        return r;
    endfunction

    // Compare process: all outputs against the expectations, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("brbselect", brbselect, exp_brb);
            check("busy",      CB'(busy),      CB'(exp_busy));
            check("cfg_ready", CB'(cfg_ready), CB'(exp_ready));
            check("done",      CB'(done),      CB'(exp_done));
            check("cfg_err",   CB'(cfg_err),   CB'(exp_err));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic a, input logic v, input logic [WW-1:0] d);
        start = s; abort = a; cfg_valid = v; cfg_data = d;
    endtask

    task automatic expect_idle();
        exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0;
    endtask

    task automatic idle_cycle();
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        expect_idle();
    endtask

    // One load. same_cycle issues start in the current (done) cycle.
    // abort_at / reset_at / glitch_at: word index where that event happens, -1 for none.
    task automatic run_load(input words_t w, input bit toggle, input int abort_at,
                            input int reset_at, input int glitch_at, input bit same_cycle);
        bit pad_bad;
        pad_bad = (w[NW-1] >> (CB - (NW - 1) * WW)) != 0;
        if (!same_cycle) begin
            next_cycle();
            expect_idle();
        end
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < NW; k++) begin
            if (toggle && k > 0) begin
                next_cycle();
                set_in(1'b0, 1'b0, 1'b0, 8'hC3);
                exp_busy = 1'b1; exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
            end
            next_cycle();
            if (k == reset_at) begin
                rst_n = 1'b0;
                set_in(1'b0, 1'b0, 1'b0, 8'h00);
                expect_idle();
                exp_err = 1'b0;
                exp_brb = '0;
                return;
            end
            set_in(k == glitch_at, k == abort_at, 1'b1, w[k]);
            exp_busy = 1'b1; exp_ready = (k != abort_at); exp_done = 1'b0; exp_err = 1'b0;
            if (k == abort_at) begin
                idle_cycle();
                return;
            end
        end
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        if (pad_bad) begin
            expect_idle();
            exp_err = 1'b1;
            return;
        end
        exp_busy = 1'b1; exp_ready = 1'b0; exp_done = 1'b0;
        next_cycle();
        expect_idle();
        exp_done = 1'b1;
        exp_brb  = build(w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        words_t w1, ones, w4, w5, w6;
        for (int k = 0; k < NW; k++) begin
            w1[k]   = WW'(k);
            ones[k] = 8'hFF;
            w5[k]   = WW'(8'hA5 ^ (k * 7));
            w6[k]   = WW'(8'h3C + k * 11);
        end
        w1[NW-1]   = 8'h0A;
        ones[NW-1] = 8'h0F;
        w4         = w1;
        w4[NW-1]   = 8'hFF;
        w5[NW-1]   = 8'h06;
        w6[NW-1]   = 8'h09;

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        expect_idle();
        exp_err = 1'b0;
        exp_brb = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle_cycle();

        // 1: continuous stream, then pin the model with literal slices
        run_load(w1, 1'b0, -1, -1, -1, 1'b0);
        check("lit_low_byte",  CB'(brbselect[7:0]),     CB'(8'h00));
        check("lit_byte1",     CB'(brbselect[15:8]),    CB'(8'h01));
        check("lit_byte21",    CB'(brbselect[175:168]), CB'(8'h15));
        check("lit_pad_nib",   CB'(brbselect[179:176]), CB'(4'hA));
        check("lit_done",      CB'(done),               CB'(1'b1));

        // 2: same stream with toggling valid, started back-to-back in the done cycle
        run_load(w1, 1'b1, -1, -1, -1, 1'b1);
        idle_cycle();

        // 3: full all-ones load, then a second load aborted after 10 words
        run_load(ones, 1'b0, -1, -1, -1, 1'b0);
        check("lit_all_ones", brbselect, {CB{1'b1}});
        idle_cycle();
        run_load(w1, 1'b0, 10, -1, -1, 1'b0);
        idle_cycle();
        check("lit_ones_kept", brbselect, {CB{1'b1}});

        // 4: pad error, then the next start clears cfg_err
        run_load(w4, 1'b0, -1, -1, -1, 1'b0);
        idle_cycle();
        check("lit_err_set", CB'(cfg_err), CB'(1'b1));
        run_load(w1, 1'b0, -1, -1, -1, 1'b0);
        idle_cycle();

        // 5: reset after 12 words, then a full load
        run_load(w6, 1'b0, -1, 12, -1, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        check("lit_reset_brb", brbselect, '0);
        idle_cycle();
        run_load(w5, 1'b0, -1, -1, -1, 1'b0);
        idle_cycle();

        // 6: start+abort in IDLE stays idle; start during LOAD is ignored
        next_cycle();
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        expect_idle();
        idle_cycle();
        idle_cycle();
        run_load(w6, 1'b1, -1, -1, 5, 1'b0);
        idle_cycle();
        idle_cycle();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
